// File: rtl/dsp_pkg.sv
// Shared constants and select encodings for the DSP48A1 post-adder/accumulator.
package dsp_pkg;

  // Datapath widths: P/C/PCIN/D:A:B are 48 bits, the product is 36 bits.
  // The adder is one bit wider so the carry/borrow out is bit 48.
  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int R_W = P_W + 1;

  // OPMODE field positions. Bits 4 and 6 belong to the pre-adder and are not used here.
  localparam int OP_X_LSB = 0;
  localparam int OP_Z_LSB = 2;
  localparam int OP_CIN   = 5;
  localparam int OP_SUB   = 7;

  // X operand select, opmode[1:0].
  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  // Z operand select, opmode[3:2].
  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with clock enable and async active-low clear.
// With BYPASS set the output follows the input combinationally; the flop is
// still described so every port stays connected, and synthesis drops it.
module dsp_pipe_reg #(
  parameter int WIDTH  = 1,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Storage: reset wins over the enable; a low enable holds the value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (ce) begin
      data_q <= d_i;
    end
  end

  assign q_o = BYPASS ? d_i : data_q;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: selects X and Z under OPMODE control,
// computes Z +/- (X + CIN) in 49 bits and registers P and CARRYOUT.
// P fed back through X or Z forms the multiply-accumulate loop.
module dsp_post_adder_acc
  import dsp_pkg::*;
#(
  parameter bit    PREG        = 1'b1,
  parameter bit    CARRYOUTREG = 1'b1,
  parameter bit    CARRYINREG  = 1'b1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cep,
  input  logic           cecarryin,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] dab,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           carryoutf
);

  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  x_sel_e         x_sel;
  z_sel_e         z_sel;
  logic [P_W-1:0] x_val;
  logic [P_W-1:0] z_val;
  logic [P_W-1:0] p_fb;
  logic [R_W-1:0] r;
  logic [P_W-1:0] p_d;
  logic [P_W-1:0] p_q;
  logic           co_d;
  logic           co_q;
  logic           cin_src;
  logic           cin_q;
  logic           unused_ok;

  // Pre-adder control bits arrive on the same bus but have no effect here.
  assign unused_ok = ^{opmode[6], opmode[4]};

  assign x_sel = x_sel_e'(opmode[OP_X_LSB +: 2]);
  assign z_sel = z_sel_e'(opmode[OP_Z_LSB +: 2]);

  // Carry-in source: opmode[5] or the external pin.
  assign cin_src = CIN_FROM_PORT ? carryin : opmode[OP_CIN];

  // CYI register; only the carry is delayed, the rest of opmode is not.
  dsp_pipe_reg #(
    .WIDTH  (1),
    .BYPASS (!CARRYINREG)
  ) u_cyi (
    .clk (clk),
    .rst (rst),
    .ce  (cecarryin),
    .d_i (cin_src),
    .q_o (cin_q)
  );

  // Without a P register the feedback would be a combinational loop, so
  // selecting P reads as zero in that configuration.
  if (PREG) begin : g_pfb_reg
    assign p_fb = p_q;
  end else begin : g_pfb_zero
    assign p_fb = '0;
  end

  // X operand mux; the product is zero-extended to 48 bits.
  always_comb begin
    x_val = '0;
    case (x_sel)
      X_ZERO:  x_val = '0;
      X_M:     x_val = {{(P_W-M_W){1'b0}}, m};
      X_P:     x_val = p_fb;
      X_DAB:   x_val = dab;
      default: x_val = '0;
    endcase
  end

  // Z operand mux.
  always_comb begin
    z_val = '0;
    case (z_sel)
      Z_ZERO:  z_val = '0;
      Z_PCIN:  z_val = pcin;
      Z_P:     z_val = p_fb;
      Z_C:     z_val = c;
      default: z_val = '0;
    endcase
  end

  // 49-bit add/subtract; in subtract mode the carry joins X before the
  // subtraction so bit 48 is the two's-complement sign/borrow.
  always_comb begin
    r = '0;
    if (opmode[OP_SUB]) begin
      r = {1'b0, z_val} - ({1'b0, x_val} + R_W'(cin_q));
    end else begin
      r = {1'b0, z_val} + {1'b0, x_val} + R_W'(cin_q);
    end
  end

  assign p_d  = r[P_W-1:0];
  assign co_d = r[P_W];

  // P register, enabled by cep.
  dsp_pipe_reg #(
    .WIDTH  (P_W),
    .BYPASS (!PREG)
  ) u_p (
    .clk (clk),
    .rst (rst),
    .ce  (cep),
    .d_i (p_d),
    .q_o (p_q)
  );

  // CARRYOUT register, enabled by cecarryin independently of cep.
  dsp_pipe_reg #(
    .WIDTH  (1),
    .BYPASS (!CARRYOUTREG)
  ) u_co (
    .clk (clk),
    .rst (rst),
    .ce  (cecarryin),
    .d_i (co_d),
    .q_o (co_q)
  );

  assign p         = p_q;
  assign pcout     = p_q;
  assign carryout  = co_q;
  assign carryoutf = co_q;

endmodule

// File: doc/dsp_post_adder_acc.md
# dsp_post_adder_acc

Post-adder/accumulator stage of the DSP48A1 slice, directly downstream of the multiplier's M-register mux/register stage. It takes the 36-bit product plus the C, D:A:B and PCIN operands and selects X and Z operands under OPMODE control. It computes Z ± (X + CIN) in 48 bits with carry, and registers the result into the P and CARRYOUT pipeline registers. With the P feedback path it forms the slice's multiply-accumulate loop and drives PCOUT to the next slice in the cascade.

## Interface
- PREG, 1, 1 = P output registered; 0 = combinational P.
- CARRYOUTREG, 1, 1 = CARRYOUT registered; 0 = combinational.
- CARRYINREG, 1, 1 = carry-in (CYI) registered; 0 = combinational.
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" = opmode[5]; "CARRYIN" = port carryin.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; clears P, CARRYOUT and CYI registers.
- cep  in  1  clock enable for the P register.
- cecarryin  in  1  clock enable for the CYI and CARRYOUT registers.
- opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry-in value, [7] subtract; [4] and [6] are ignored.
- m  in  36  product from the M stage.
- dab  in  48  {D[11:0], A[17:0], B[17:0]} concatenation.
- c  in  48  C operand.
- pcin  in  48  cascade input from the previous slice.
- carryin  in  1  external carry-in.
- p  out  48  result.
- pcout  out  48  copy of p.
- carryout  out  1  bit 48 of the post-adder result.
- carryoutf  out  1  copy of carryout.

## Operation
- X select opmode[1:0]: 0 → 0; 1 → {12'b0, m}; 2 → p; 3 → dab.
- Z select opmode[3:2]: 0 → 0; 1 → pcin; 2 → p; 3 → c.
- CIN = CYI register output, or the selected source directly when CARRYINREG=0.
- Add (opmode[7]=0): r[48:0] = Z + X + CIN, all operands zero-extended to 49 bits.
- Subtract (opmode[7]=1): r[48:0] = Z − (X + CIN) in 49-bit two's complement.
- p = r[47:0] and carryout = r[48], each through its optional register.
- Result wraps modulo 2^48; no saturation.
- With PREG=0, any X or Z select of p yields 0. This breaks the combinational loop and is legal.
- Registers and reset:
  - Reset values: p=0, pcout=0, carryout=0, carryoutf=0, CYI=0.
  - Reset dominates the enables and acts without waiting for a clock edge.
  - With an enable low, the corresponding register holds its value.
- No state machine. State is the P, CARRYOUT and CYI registers; the accumulator loop is P fed back through X or Z.

## Timing
- PREG=1: p reflects the inputs one rising edge after they are sampled.
- PREG=0: p follows the inputs combinationally.
- CARRYINREG=1 adds one cycle from the carry source to its effect on r. opmode[7:0] other than [5] is not delayed.
- Accumulate (Z=P, X=M) updates p once per enabled cycle, using the p value held before the edge.
- Reset asserted mid-accumulation clears p immediately. The first enabled edge after release accumulates from 0.
- cep low on an edge: p holds, and carryout still updates if cecarryin=1. The two enables are independent.

## Structure
- Shared package dsp_pkg holds:
  - opmode field index constants;
  - X/Z select encodings (X_ZERO, X_M, X_P, X_DAB, Z_ZERO, Z_PCIN, Z_P, Z_C);
  - the width constants (48, 36).
- One natural sub-module: dsp_pipe_reg.
  - Parameterized WIDTH and BYPASS; clk, rst (async active-low), ce.
  - Instantiated for P, CARRYOUT and CYI.
- X/Z muxes and the 49-bit adder/subtractor stay in the top.

## Test plan
- Add: opmode=8'b0000_1101 (X=M, Z=C), m=1000, c=24, all REG=1 → p=1024, carryout=0 one edge later.
- Accumulate: release reset, opmode=8'b0000_1001 (X=M, Z=P), m=5 for 4 edges → p=5, 10, 15, 20. Drop cep for 2 edges → p holds 20.
- Subtract with carry: opmode=8'b1010_1101, c=100, m=30, CARRYINSEL="OPMODE5", CARRYINREG=0 → p=69.
- Wrap: opmode=8'b0000_1101, c=48'hFFFF_FFFF_FFFF, m=1 → p=0, carryout=1, carryoutf=1.
- Reset mid-run: during accumulate at p=15, pull rst low between edges → p=0 and carryout=0 before the next edge. After release and one edge, p=5.
- Bypass: PREG=0, CARRYOUTREG=0, X=DAB, Z=PCIN, dab=7, pcin=3 → p=10 in the same cycle. X select=P → p equals Z only.
